// File: rtl/sw_seq_feeder.sv
// sw_seq_feeder
//   Front end of the Smith-Waterman systolic PE array. Unpacks the query (s)
//   and target (t) sequences from a packed word stream. s is shifted into the
//   array's s chain with valid low. t is then streamed one base per cycle with
//   valid high, followed by a drain of pad bases. The final max score is
//   captured from the last PE and reported with a one-cycle done pulse.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, len_s, len_t      job request; lengths sampled on start
//   in_valid/in_data/in_ready packed base words (base 0 in the LSBs)
//   s_out, s_shift           query base and shift enable for the s chain
//   t_out, valid_out         target base and valid into PE0
//   v_out, f_out, max_out    PE0 boundary inputs (always zero)
//   len_s_q                  latched query length for the array
//   max_in                   max_out of the last PE
//   score, done, err, busy   result, end-of-job pulse, t underflow, activity
module sw_seq_feeder #(
  parameter int BP_WIDTH   = 2,
  parameter int DATA_WIDTH = 16,
  parameter int WORD_WIDTH = 32,
  parameter int NUM_PE     = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int PIPE_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len_s,
  input  logic [LEN_WIDTH-1:0]  len_t,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [BP_WIDTH-1:0]   s_out,
  output logic                  s_shift,
  output logic [BP_WIDTH-1:0]   t_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] v_out,
  output logic [DATA_WIDTH-1:0] f_out,
  output logic [DATA_WIDTH-1:0] max_out,
  output logic [LEN_WIDTH-1:0]  len_s_q,
  input  logic [DATA_WIDTH-1:0] max_in,
  output logic [DATA_WIDTH-1:0] score,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  localparam int BPW   = WORD_WIDTH / BP_WIDTH;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CNT_W = LEN_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_S,
    PRIME,
    STREAM_T,
    DRAIN,
    DONE
  } state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [LEN_WIDTH-1:0]  len_t_reg;

  // Two-entry word buffer
  logic [WORD_WIDTH-1:0] buf_mem [2];
  logic                  buf_wr_ptr_reg;
  logic                  buf_rd_ptr_reg;
  logic [1:0]            buf_count_reg;
  logic [IDX_W-1:0]      base_idx_reg;

  logic [BP_WIDTH-1:0]   head_bases [BPW];
  logic [BP_WIDTH-1:0]   cur_base;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  base_take;
  logic                  seq_last;
  logic                  buf_empty;
  logic                  buf_full;
  logic                  prime_ok;
  logic [CNT_W-1:0]      seq_len;
  logic [CNT_W-1:0]      t_words;
  logic [CNT_W-1:0]      drain_end;

  assign v_out   = '0;
  assign f_out   = '0;
  assign max_out = '0;

  assign busy = (state_reg != IDLE);

  assign buf_empty = (buf_count_reg == 2'd0);
  assign buf_full  = (buf_count_reg == 2'd2);

  // PRIME must be able to fill the buffer, otherwise it could never leave.
  assign in_ready = !buf_full &&
                    ((state_reg == LOAD_S) || (state_reg == PRIME) || (state_reg == STREAM_T));
  assign push     = in_valid && in_ready;
  assign flush    = (state_reg == IDLE) && start;

  // Split the head word into bases, base 0 from the LSBs.
  for (genvar gi = 0; gi < BPW; gi++) begin : g_unpack
    assign head_bases[gi] = buf_mem[buf_rd_ptr_reg][gi*BP_WIDTH +: BP_WIDTH];
  end
  assign cur_base = head_bases[base_idx_reg];

  // cnt_reg counts s bases in LOAD_S and valid cycles from STREAM_T onward.
  assign seq_len  = (state_reg == LOAD_S) ? {1'b0, len_s_q} : {1'b0, len_t_reg};
  assign seq_last = ((cnt_reg + CNT_W'(1)) == seq_len);

  assign base_take = ((state_reg == LOAD_S) || (state_reg == STREAM_T)) && !buf_empty;
  // A word is released after its last base or after the sequence's last base,
  // which discards the unused tail and makes t start on a fresh word.
  assign pop = base_take && ((base_idx_reg == IDX_W'(BPW - 1)) || seq_last);

  assign t_words   = ({1'b0, len_t_reg} + CNT_W'(BPW - 1)) / CNT_W'(BPW);
  assign prime_ok  = buf_full || ({{(CNT_W-2){1'b0}}, buf_count_reg} >= t_words);
  // Number of valid cycles: t bases plus the array pipeline depth.
  assign drain_end = {1'b0, len_t_reg} + CNT_W'(NUM_PE + PIPE_LAT);

  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[buf_wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      buf_wr_ptr_reg <= 1'b0;
      buf_rd_ptr_reg <= 1'b0;
      buf_count_reg  <= 2'd0;
      base_idx_reg   <= '0;
    end else begin
      if (push) begin
        buf_wr_ptr_reg <= ~buf_wr_ptr_reg;
      end
      if (pop) begin
        buf_rd_ptr_reg <= ~buf_rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   buf_count_reg <= buf_count_reg + 2'd1;
        2'b01:   buf_count_reg <= buf_count_reg - 2'd1;
        default: buf_count_reg <= buf_count_reg;
      endcase
      if (pop) begin
        base_idx_reg <= '0;
      end else if (base_take) begin
        base_idx_reg <= base_idx_reg + IDX_W'(1);
      end
    end
  end

  // Control FSM; every array-facing output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      len_t_reg <= '0;
      len_s_q   <= '0;
      s_shift   <= 1'b0;
      s_out     <= '0;
      t_out     <= '0;
      valid_out <= 1'b0;
      score     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      s_shift   <= 1'b0;
      s_out     <= '0;
      t_out     <= '0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if ((len_s == '0) || (len_s > LEN_WIDTH'(NUM_PE)) || (len_t == '0)) begin
              err       <= 1'b1;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              len_s_q   <= len_s;
              len_t_reg <= len_t;
              err       <= 1'b0;
              cnt_reg   <= '0;
              state_reg <= LOAD_S;
            end
          end
        end
        LOAD_S: begin
          if (base_take) begin
            s_shift <= 1'b1;
            s_out   <= cur_base;
            if (seq_last) begin
              cnt_reg   <= '0;
              state_reg <= PRIME;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        PRIME: begin
          if (prime_ok) begin
            state_reg <= STREAM_T;
          end
        end
        STREAM_T: begin
          if (buf_empty) begin
            // Source fell behind: the stream cannot stall, so abort.
            err       <= 1'b1;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            valid_out <= 1'b1;
            t_out     <= cur_base;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (seq_last) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // cnt_reg == drain_end means the cycle now on the outputs is the
          // last valid one, whose max_in carries the final score.
          if (cnt_reg == drain_end) begin
            score     <= max_in;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            valid_out <= 1'b1;
            cnt_reg   <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_seq_feeder.sv
module tb_sw_seq_feeder;

  localparam int BP_WIDTH   = 2;
  localparam int DATA_WIDTH = 16;
  localparam int WORD_WIDTH = 32;
  localparam int NUM_PE     = 64;
  localparam int LEN_WIDTH  = 16;
  localparam int PIPE_LAT   = 2;
  localparam int BPW        = WORD_WIDTH / BP_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [LEN_WIDTH-1:0]  len_s;
  logic [LEN_WIDTH-1:0]  len_t;
  logic                  in_valid;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [BP_WIDTH-1:0]   s_out;
  logic                  s_shift;
  logic [BP_WIDTH-1:0]   t_out;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] v_out;
  logic [DATA_WIDTH-1:0] f_out;
  logic [DATA_WIDTH-1:0] max_out;
  logic [LEN_WIDTH-1:0]  len_s_q;
  logic [DATA_WIDTH-1:0] max_in;
  logic [DATA_WIDTH-1:0] score;
  logic                  done;
  logic                  err;
  logic                  busy;

  sw_seq_feeder #(
    .BP_WIDTH(BP_WIDTH), .DATA_WIDTH(DATA_WIDTH), .WORD_WIDTH(WORD_WIDTH),
    .NUM_PE(NUM_PE), .LEN_WIDTH(LEN_WIDTH), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len_s(len_s), .len_t(len_t),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .s_out(s_out), .s_shift(s_shift), .t_out(t_out), .valid_out(valid_out),
    .v_out(v_out), .f_out(f_out), .max_out(max_out), .len_s_q(len_s_q),
    .max_in(max_in), .score(score), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // ls, lt, mode (1: 50% gaps on s words), drop (words delivered, -1 all),
  // fixed (ACGT pattern), busy_start (cycle of an extra start, -1 none),
  // rst_v (reset after this many valid cycles, -1 none), exp_err, exp_score (-1 model)
  typedef struct {
    int ls;
    int lt;
    int mode;
    int drop;
    int fixed;
    int busy_start;
    int rst_v;
    int exp_err;
    int exp_score;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int held_score = 0;
  int s_seq[$];
  int t_seq[$];
  logic [WORD_WIDTH-1:0] words[$];
  int nsw;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Smith-Waterman local alignment: match +2, mismatch -1, linear gap -1.
  function automatic int sw_ref(input int a[$], input int b[$]);
    int prev[$];
    int cur[$];
    int best;
    int h;
    best = 0;
    for (int i = 0; i <= a.size(); i++) begin
      prev.push_back(0);
      cur.push_back(0);
    end
    foreach (b[j]) begin
      for (int i = 1; i <= a.size(); i++) begin
        h = prev[i-1] + ((a[i-1] == b[j]) ? 2 : -1);
        if (prev[i] - 1 > h) h = prev[i] - 1;
        if (cur[i-1] - 1 > h) h = cur[i-1] - 1;
        if (h < 0) h = 0;
        cur[i] = h;
        if (h > best) best = h;
      end
      prev = cur;
    end
    return best;
  endfunction

  task automatic pack(input int q[$]);
    int nw;
    logic [WORD_WIDTH-1:0] wd;
    nw = (q.size() + BPW - 1) / BPW;
    for (int w = 0; w < nw; w++) begin
      wd = $urandom;
      for (int k = 0; k < BPW; k++) begin
        if (w * BPW + k < q.size()) wd[k*BP_WIDTH +: BP_WIDTH] = BP_WIDTH'(q[w*BPW + k]);
      end
      words.push_back(wd);
    end
  endtask

  task automatic build_job(input int ls, input int lt, input int fixed);
    s_seq.delete();
    t_seq.delete();
    words.delete();
    for (int i = 0; i < ls; i++) s_seq.push_back(fixed != 0 ? i % 4 : int'($urandom_range(0, 3)));
    for (int i = 0; i < lt; i++) t_seq.push_back(fixed != 0 ? i % 4 : int'($urandom_range(0, 3)));
    nsw = (ls + BPW - 1) / BPW;
    pack(s_seq);
    pack(t_seq);
  endtask

  task automatic run_job(input vec_t v);
    int ndeliv, avail, exp_err, exp_valid, exp_score;
    int wptr, shifts, vcnt, both, t_bad, s_bad, cyc, t0, done_cyc, m, extra;
    int tp[$];
    int arr_s[$];
    int arr_t[$];
    bit done_seen, err_seen, aborted;
    build_job(v.ls, v.lt, v.fixed);
    ndeliv    = (v.drop < 0) ? words.size() : v.drop;
    avail     = (ndeliv - nsw) * BPW;
    if (avail > v.lt) avail = v.lt;
    exp_err   = (avail < v.lt) ? 1 : 0;
    exp_valid = (exp_err != 0) ? avail : v.lt + NUM_PE + PIPE_LAT;
    if (exp_err != 0) exp_score = held_score;
    else if (v.exp_score >= 0) exp_score = v.exp_score;
    else exp_score = sw_ref(s_seq, t_seq);

    wptr = 0; shifts = 0; vcnt = 0; both = 0; t_bad = 0; s_bad = 0;
    cyc = 0; t0 = -1; done_cyc = -1;
    done_seen = 0; err_seen = 0; aborted = 0;
    in_valid = 1'b0;
    start = 1'b1;
    len_s = LEN_WIDTH'(v.ls);
    len_t = LEN_WIDTH'(v.lt);
    @(negedge clk);
    start = 1'b0;
    check("score_hold", int'(score), held_score);
    while (!done_seen && cyc < 3000) begin
      if (s_shift) begin
        arr_s.push_back(int'(s_out));
        shifts++;
      end
      if (valid_out) begin
        arr_t.push_back(int'(t_out));
        if (vcnt < v.lt) begin
          if (int'(t_out) != t_seq[vcnt]) t_bad++;
        end else if (t_out != '0) begin
          t_bad++;
        end
        if (vcnt == 0) t0 = cyc;
        vcnt++;
      end
      if (s_shift && valid_out) both++;
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        err_seen  = err;
      end
      if (v.rst_v >= 0 && vcnt == v.rst_v) begin
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_s_shift", int'(s_shift), 0);
        check("rst_t_out", int'(t_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_score", int'(score), 0);
        check("rst_len_s_q", int'(len_s_q), 0);
        extra = 0;
        repeat (4) begin
          @(negedge clk);
          if (done) extra++;
        end
        check("rst_no_done", extra, 0);
        held_score = 0;
        aborted = 1;
        $display("[TB] job ls=%0d lt=%0d aborted by reset after %0d valid cycles", v.ls, v.lt, vcnt);
        break;
      end
      // Array model: max_in reflects t bases whose contribution has left the last PE.
      m = vcnt - NUM_PE - PIPE_LAT;
      if (m > 0) begin
        tp = arr_t[0:m-1];
        max_in = DATA_WIDTH'(sw_ref(arr_s, tp));
      end else begin
        max_in = '0;
      end
      start = (cyc == v.busy_start) ? 1'b1 : 1'b0;
      if (wptr < ndeliv) begin
        in_valid = (v.mode == 1 && wptr < nsw) ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = words[wptr];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) wptr++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (!aborted) begin
      foreach (s_seq[i]) begin
        if (i < arr_s.size()) begin
          if (arr_s[i] != s_seq[i]) s_bad++;
        end
      end
      check("done_seen", int'(done_seen), 1);
      check("err", int'(err_seen), v.exp_err);
      check("s_shifts", shifts, v.ls);
      check("s_bases_bad", s_bad, 0);
      check("valid_cycles", vcnt, exp_valid);
      check("t_bases_bad", t_bad, 0);
      check("shift_and_valid", both, 0);
      check("done_latency", done_cyc - t0, exp_valid);
      check("done_pulse", int'(done), 0);
      check("busy_after", int'(busy), 0);
      check("score", int'(score), exp_score);
      check("len_s_q", int'(len_s_q), v.ls);
      held_score = exp_score;
      $display("[TB] job ls=%0d lt=%0d valid=%0d score=%0d err=%0d", v.ls, v.lt, vcnt, int'(score), int'(err_seen));
      if (v.busy_start >= 0) begin
        extra = 0;
        repeat (3) begin
          @(negedge clk);
          if (done) extra++;
        end
        check("busy_start_one_done", extra, 0);
      end
    end
  endtask

  task automatic run_bad(input int ls, input int lt);
    int rdy;
    rdy = 0;
    start = 1'b1;
    len_s = LEN_WIDTH'(ls);
    len_t = LEN_WIDTH'(lt);
    @(negedge clk);
    start = 1'b0;
    if (in_ready) rdy++;
    check("bad_done", int'(done), 1);
    check("bad_err", int'(err), 1);
    @(negedge clk);
    if (in_ready) rdy++;
    check("bad_done_pulse", int'(done), 0);
    check("bad_busy", int'(busy), 0);
    check("bad_in_ready", rdy, 0);
    check("bad_score_hold", int'(score), held_score);
    $display("[TB] bad job ls=%0d lt=%0d done+err", ls, lt);
  endtask

  vec_t tbl[$];
  vec_t r;

  initial begin
    rst = 1'b1; start = 1'b0; len_s = '0; len_t = '0;
    in_valid = 1'b0; in_data = '0; max_in = '0;
    repeat (3) @(negedge clk);
    check("reset_score", int'(score), 0);
    check("reset_err", int'(err), 0);
    check("reset_done", int'(done), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_s_shift", int'(s_shift), 0);
    check("reset_len_s_q", int'(len_s_q), 0);
    rst = 1'b0;
    @(negedge clk);

    tbl.push_back('{4,  4,  0, -1, 1, -1, -1, 0,  8});
    tbl.push_back('{17, 33, 1, -1, 0, -1, -1, 0, -1});
    tbl.push_back('{5,  40, 0,  3, 0, -1, -1, 1, -1});
    tbl.push_back('{64, 16, 0, -1, 0, -1, -1, 0, -1});
    tbl.push_back('{1,  1,  1, -1, 0, -1, -1, 0, -1});
    tbl.push_back('{16, 17, 0, -1, 0, 10, -1, 0, -1});
    tbl.push_back('{8,  20, 0, -1, 0, -1,  5, 0, -1});
    tbl.push_back('{12, 25, 0, -1, 0, -1, -1, 0, -1});
    tbl.push_back('{30, 9,  1, -1, 0, -1, -1, 0, -1});
    foreach (tbl[i]) run_job(tbl[i]);

    run_bad(0, 5);
    run_bad(NUM_PE + 1, 5);
    run_bad(3, 0);

    for (int k = 0; k < 12; k++) begin
      r = '{int'($urandom_range(1, NUM_PE)), int'($urandom_range(1, 80)),
            int'($urandom_range(0, 1)), -1, 0, -1, -1, 0, -1};
      run_job(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
